z2_bus_master: RTL and testbench
================================

Name: z2_bus_master

Overview:
- 68000/Zorro II bus initiator for the CIDER card.
- Takes single-word transfer requests from an internal MEMCLK-domain client (DMA or self-test engine) and acquires the bus via BR_n/BG_n/BGACK_n.
- Runs a complete read or write cycle (AS_n, UDS_n/LDS_n, RW, address, data) and terminates on DTACK_n, BERR_n or timeout.
- It is the initiator counterpart of the card's existing responder logic.

Parameters:
- ADDR_SETUP, 2, MEMCLK cycles the address and RW are driven before AS_n is asserted.
- WDATA_SETUP, 2, MEMCLK cycles after AS_n before UDS_n/LDS_n are asserted on writes.
- RDATA_DELAY, 3, MEMCLK cycles after synchronized DTACK_n before read data is latched.
- TIMEOUT_CYCLES, 1023, watchdog limit; used only with Z2M_TIMEOUT_EN.

Ports:
- MEMCLK in 1: clock.
- RESET_n in 1: reset, asynchronous, active-low.
- req_valid in 1: client request.
- req_ready out 1: accept; handshake completes when req_valid && req_ready.
- req_addr in 23: word address [23:1].
- req_rw in 1: 1=read, 0=write.
- req_wdata in 16: write data.
- req_be in 2: {upper,lower} byte enables; 2'b00 is illegal.
- req_lock in 1: keep bus ownership after this transfer.
- rsp_valid out 1: one-cycle completion pulse.
- rsp_rdata out 16: read data.
- rsp_err out 2: 00 ok, 01 BERR, 10 timeout.
- BR_n out 1: bus request.
- BG_n in 1: bus grant.
- BGACK_n_in in 1: bus grant acknowledge from another master.
- BGACK_n_out out 1: open-drain style; 0 when owning the bus, else Z-intent (see BGACK_OE).
- BGACK_OE out 1: drive enable for BGACK_n_out.
- AS_n_in in 1: address strobe as seen on the bus.
- DTACK_n in 1: data transfer acknowledge.
- BERR_n in 1: bus error.
- ADDR_OUT out 23: address.
- D_OUT out 16: write data.
- D_IN in 16: read data.
- BUS_OE out 1: enables ADDR_OUT, AS/UDS/LDS/RW drivers.
- D_OE out 1: enables D_OUT.
- AS_n_out out 1, UDS_n_out out 1, LDS_n_out out 1, RW_out out 1: bus strobes and direction.

Behaviour:
- Synchronizers: BG_n, BGACK_n_in, AS_n_in, DTACK_n, BERR_n each pass through a 2-flop synchronizer reset to 1. All decisions use the synchronized copies only.
- Reset values (while RESET_n low): BR_n=1, BGACK_OE=0, BGACK_n_out=1, BUS_OE=0, D_OE=0, AS_n_out=UDS_n_out=LDS_n_out=1, RW_out=1, ADDR_OUT=0, D_OUT=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=00, state IDLE.
- IDLE:
  - req_ready=1.
  - On handshake, latch addr/rw/wdata/be/lock and set req_ready=0.
  - If already owning the bus (locked), go to ADDR; otherwise go to ARB.
- ARB:
  - BR_n=0.
  - Wait for BG_n=0 && AS_n_in=1 && DTACK_n=1 && BGACK_n_in=1 (synchronized).
  - Then BGACK_OE=1, BGACK_n_out=0, BR_n=1 (same edge), and go to ADDR.
- ADDR:
  - BUS_OE=1, ADDR_OUT and RW_out valid.
  - On a write, D_OE=1 and D_OUT valid.
  - Stay ADDR_SETUP cycles, then go to STROBE.
- STROBE:
  - AS_n_out=0.
  - Read: UDS_n_out=~be[1] and LDS_n_out=~be[0] on the same edge, then go to WAIT.
  - Write: hold WDATA_SETUP cycles, then assert the data strobes, then go to WAIT.
- WAIT: terminate on the first of the following, evaluated in priority order:
  - BERR_n=0: rsp_err=01; takes precedence if it arrives in the same cycle as DTACK_n.
  - DTACK_n=0:
    - Read: wait RDATA_DELAY cycles, latch D_IN into rsp_rdata.
    - Write: proceed after 1 cycle.
  - Timeout (optional feature): rsp_err=10.
- RELEASE:
  - AS_n_out/UDS_n_out/LDS_n_out=1.
  - D_OE remains 1 for one further cycle, then goes to 0.
  - rsp_valid pulses for exactly 1 cycle.
  - Go to HOLD.
- HOLD:
  - Wait for DTACK_n=1 && BERR_n=1.
  - If lock: BUS_OE stays 1 with strobes negated; go to IDLE with ownership retained.
  - Else: BUS_OE=0, BGACK_n_out=1 for 1 cycle, then BGACK_OE=0; go to IDLE.
- Locked idle: in IDLE with ownership and no request, the bus is held indefinitely. Bus is released when the next completed request has lock=0.
- Reset mid-cycle: all drivers are released asynchronously; no rsp_valid is generated.
- Write data: rsp_rdata holds its previous value on writes.
- Illegal req_be=00: complete immediately without a bus cycle, with rsp_valid=1 and rsp_err=01.

Optional Feature:
- Macro: Z2M_TIMEOUT_EN.
- Defined:
  - A 10-bit counter cleared on STROBE entry and incremented each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without DTACK_n or BERR_n, go to RELEASE with rsp_err=10 and rsp_rdata=16'hFFFF.
- Undefined: no counter; WAIT may last indefinitely and rsp_err is never 10.

Test Plan:
- Read, req_addr=23'h100000, be=11, DTACK low 5 cycles after AS, D_IN=16'hA55A -> BR_n pulse; AS_n_out low ADDR_SETUP cycles after BUS_OE; UDS/LDS low with AS; rsp_valid once with rsp_rdata=A55A, rsp_err=00; BGACK released.
- Write be=10, wdata=16'h1234 -> UDS_n_out low, LDS_n_out high; data strobe 2 cycles after AS; D_OUT=1234 held 1 cycle past AS negation; rsp_err=00.
- BERR_n and DTACK_n asserted in the same cycle -> rsp_err=01; HOLD until both high.
- Two requests, first with lock=1 -> single BR_n/BG_n arbitration; BGACK_n_out stays low between transfers; released only after the second completes.
- RESET_n low during WAIT -> all OE=0 and strobes=1 asynchronously; no rsp_valid.
- Z2M_TIMEOUT_EN with TIMEOUT_CYCLES=16, no DTACK -> rsp_err=10 and rsp_rdata=FFFF after 16 WAIT cycles. Without the macro -> still waiting at cycle 1000.

Source files
------------

// File: rtl/z2_bus_master.sv
// z2_bus_master: 68000/Zorro II bus initiator running single-word read/write cycles.
// Optional watchdog: define Z2M_TIMEOUT_EN to abort stalled cycles with rsp_err=2'b10.
module z2_bus_master #(
    parameter int unsigned ADDR_SETUP     = 2,
    parameter int unsigned WDATA_SETUP    = 2,
    parameter int unsigned RDATA_DELAY    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        MEMCLK,
    input  logic        RESET_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [22:0] req_addr,
    input  logic        req_rw,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_be,
    input  logic        req_lock,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        BR_n,
    input  logic        BG_n,
    input  logic        BGACK_n_in,
    output logic        BGACK_n_out,
    output logic        BGACK_OE,
    input  logic        AS_n_in,
    input  logic        DTACK_n,
    input  logic        BERR_n,
    output logic [22:0] ADDR_OUT,
    output logic [15:0] D_OUT,
    input  logic [15:0] D_IN,
    output logic        BUS_OE,
    output logic        D_OE,
    output logic        AS_n_out,
    output logic        UDS_n_out,
    output logic        LDS_n_out,
    output logic        RW_out
);

    typedef enum logic [3:0] {
        StIdle,
        StArb,
        StAddr,
        StStrobe,
        StWait,
        StRdDelay,
        StWrAck,
        StRelease,
        StHold,
        StDrop
    } state_t;

    state_t      state;
    logic [4:0]  sync1;
    logic [4:0]  sync2;
    logic        bg_s;
    logic        bgack_s;
    logic        as_s;
    logic        dtack_s;
    logic        berr_s;
    logic        lat_rw;
    logic [1:0]  lat_be;
    logic        lat_lock;
    logic        owned;
    logic [7:0]  cnt;
`ifdef Z2M_TIMEOUT_EN
    logic [9:0]  tmo;
`endif

    always_ff @(posedge MEMCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {BG_n, BGACK_n_in, AS_n_in, DTACK_n, BERR_n};
            sync2 <= sync1;
        end
    end

    assign {bg_s, bgack_s, as_s, dtack_s, berr_s} = sync2;

    always_ff @(posedge MEMCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state       <= StIdle;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 2'b00;
            BR_n        <= 1'b1;
            BGACK_n_out <= 1'b1;
            BGACK_OE    <= 1'b0;
            ADDR_OUT    <= '0;
            D_OUT       <= '0;
            BUS_OE      <= 1'b0;
            D_OE        <= 1'b0;
            AS_n_out    <= 1'b1;
            UDS_n_out   <= 1'b1;
            LDS_n_out   <= 1'b1;
            RW_out      <= 1'b1;
            lat_rw      <= 1'b1;
            lat_be      <= 2'b00;
            lat_lock    <= 1'b0;
            owned       <= 1'b0;
            cnt         <= '0;
`ifdef Z2M_TIMEOUT_EN
            tmo         <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        lat_rw    <= req_rw;
                        lat_be    <= req_be;
                        lat_lock  <= req_lock;
                        if (req_be == 2'b00) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 2'b01;
                        end else begin
                            // Address/data only become visible once BUS_OE/D_OE are raised.
                            ADDR_OUT <= req_addr;
                            RW_out   <= req_rw;
                            if (!req_rw) begin
                                D_OUT <= req_wdata;
                            end
                            if (owned) begin
                                D_OE  <= ~req_rw;
                                cnt   <= '0;
                                state <= StAddr;
                            end else begin
                                BR_n  <= 1'b0;
                                state <= StArb;
                            end
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                StArb: begin
                    if (!bg_s && as_s && dtack_s && bgack_s) begin
                        BR_n        <= 1'b1;
                        BGACK_OE    <= 1'b1;
                        BGACK_n_out <= 1'b0;
                        owned       <= 1'b1;
                        BUS_OE      <= 1'b1;
                        D_OE        <= ~lat_rw;
                        cnt         <= '0;
                        state       <= StAddr;
                    end
                end
                StAddr: begin
                    if (cnt == 8'(ADDR_SETUP - 1)) begin
                        AS_n_out <= 1'b0;
                        if (lat_rw) begin
                            UDS_n_out <= ~lat_be[1];
                            LDS_n_out <= ~lat_be[0];
                        end
                        cnt   <= '0;
`ifdef Z2M_TIMEOUT_EN
                        tmo   <= '0;
`endif
                        state <= StStrobe;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                StStrobe: begin
                    if (lat_rw) begin
                        state <= StWait;
                    end else if (cnt == 8'(WDATA_SETUP - 1)) begin
                        UDS_n_out <= ~lat_be[1];
                        LDS_n_out <= ~lat_be[0];
                        state     <= StWait;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                StWait: begin
                    // BERR wins over a simultaneous DTACK.
                    if (!berr_s) begin
                        rsp_err <= 2'b01;
                        state   <= StRelease;
                    end else if (!dtack_s) begin
                        rsp_err <= 2'b00;
                        cnt     <= '0;
                        state   <= lat_rw ? StRdDelay : StWrAck;
`ifdef Z2M_TIMEOUT_EN
                    end else if (32'(tmo) + 32'd1 == TIMEOUT_CYCLES) begin
                        rsp_err   <= 2'b10;
                        rsp_rdata <= 16'hFFFF;
                        state     <= StRelease;
                    end else begin
                        tmo <= tmo + 10'd1;
`endif
                    end
                end
                StRdDelay: begin
                    if (cnt == 8'(RDATA_DELAY - 1)) begin
                        rsp_rdata <= D_IN;
                        state     <= StRelease;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                StWrAck: begin
                    state <= StRelease;
                end
                StRelease: begin
                    AS_n_out  <= 1'b1;
                    UDS_n_out <= 1'b1;
                    LDS_n_out <= 1'b1;
                    rsp_valid <= 1'b1;
                    state     <= StHold;
                end
                StHold: begin
                    // Write data stays driven one cycle past strobe negation.
                    D_OE <= 1'b0;
                    if (dtack_s && berr_s) begin
                        if (lat_lock) begin
                            state <= StIdle;
                        end else begin
                            BUS_OE      <= 1'b0;
                            BGACK_n_out <= 1'b1;
                            state       <= StDrop;
                        end
                    end
                end
                StDrop: begin
                    BGACK_OE <= 1'b0;
                    owned    <= 1'b0;
                    state    <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z2_bus_master.sv
// Directed bench for z2_bus_master: a small bus responder plus an edge monitor.
// Define Z2M_TIMEOUT_EN to exercise the watchdog with TIMEOUT_CYCLES=16.
module tb_z2_bus_master;

`ifdef Z2M_TIMEOUT_EN
    localparam int unsigned TmoCycles = 16;
`else
    localparam int unsigned TmoCycles = 1023;
`endif

    logic        MEMCLK = 1'b0;
    logic        RESET_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [22:0] req_addr = '0;
    logic        req_rw = 1'b1;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be = 2'b11;
    logic        req_lock = 1'b0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        BR_n;
    logic        BG_n = 1'b1;
    logic        BGACK_n_in = 1'b1;
    logic        BGACK_n_out;
    logic        BGACK_OE;
    logic        AS_n_in = 1'b1;
    logic        DTACK_n = 1'b1;
    logic        BERR_n = 1'b1;
    logic [22:0] ADDR_OUT;
    logic [15:0] D_OUT;
    logic [15:0] D_IN = '0;
    logic        BUS_OE;
    logic        D_OE;
    logic        AS_n_out;
    logic        UDS_n_out;
    logic        LDS_n_out;
    logic        RW_out;

    int n_checks = 0;
    int n_errors = 0;

    z2_bus_master #(.TIMEOUT_CYCLES(TmoCycles)) dut (
        .MEMCLK      (MEMCLK),
        .RESET_n     (RESET_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_rw      (req_rw),
        .req_wdata   (req_wdata),
        .req_be      (req_be),
        .req_lock    (req_lock),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .BR_n        (BR_n),
        .BG_n        (BG_n),
        .BGACK_n_in  (BGACK_n_in),
        .BGACK_n_out (BGACK_n_out),
        .BGACK_OE    (BGACK_OE),
        .AS_n_in     (AS_n_in),
        .DTACK_n     (DTACK_n),
        .BERR_n      (BERR_n),
        .ADDR_OUT    (ADDR_OUT),
        .D_OUT       (D_OUT),
        .D_IN        (D_IN),
        .BUS_OE      (BUS_OE),
        .D_OE        (D_OE),
        .AS_n_out    (AS_n_out),
        .UDS_n_out   (UDS_n_out),
        .LDS_n_out   (LDS_n_out),
        .RW_out      (RW_out)
    );

    always #5 MEMCLK = ~MEMCLK;

    int cyc = 0;
    always @(posedge MEMCLK) cyc <= cyc + 1;

    // Edge monitor, sampled on the falling clock edge.
    int          t_busoe_rise = 0, t_as_fall = 0, t_as_rise = 0, t_uds_fall = 0;
    int          t_lds_fall = 0, t_doe_fall = 0, t_rsp = 0;
    int          n_as_fall = 0, n_uds_fall = 0, n_lds_fall = 0, n_br_fall = 0;
    int          n_bgack_rise = 0, n_rsp = 0;
    logic [22:0] addr_at_as = '0;
    logic        rw_at_as = 1'b1;
    logic [15:0] dout_at_as_rise = '0;
    logic [15:0] last_rdata = '0;
    logic [1:0]  last_err = '0;
    logic        p_bus_oe = 1'b0, p_as = 1'b1, p_uds = 1'b1, p_lds = 1'b1;
    logic        p_doe = 1'b0, p_br = 1'b1, p_bgack = 1'b1;

    always @(negedge MEMCLK) begin
        if (BUS_OE === 1'b1 && !p_bus_oe) t_busoe_rise = cyc;
        if (AS_n_out === 1'b0 && p_as) begin
            t_as_fall  = cyc;
            n_as_fall++;
            addr_at_as = ADDR_OUT;
            rw_at_as   = RW_out;
        end
        if (AS_n_out === 1'b1 && !p_as) begin
            t_as_rise       = cyc;
            dout_at_as_rise = D_OUT;
        end
        if (UDS_n_out === 1'b0 && p_uds) begin t_uds_fall = cyc; n_uds_fall++; end
        if (LDS_n_out === 1'b0 && p_lds) begin t_lds_fall = cyc; n_lds_fall++; end
        if (D_OE === 1'b0 && p_doe) t_doe_fall = cyc;
        if (BR_n === 1'b0 && p_br) n_br_fall++;
        if (BGACK_n_out === 1'b1 && !p_bgack) n_bgack_rise++;
        if (rsp_valid === 1'b1) begin
            n_rsp++;
            t_rsp      = cyc;
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
        end
        p_bus_oe = BUS_OE;
        p_as     = AS_n_out;
        p_uds    = UDS_n_out;
        p_lds    = LDS_n_out;
        p_doe    = D_OE;
        p_br     = BR_n;
        p_bgack  = BGACK_n_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge MEMCLK);
            #1;
        end
    endtask

    task automatic issue(input logic [22:0] a, input logic rw, input logic [15:0] wd,
                         input logic [1:0] be, input logic lock);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin tick(); n++; end
        check("req_ready", 32'(req_ready), 32'd1);
        req_addr  = a;
        req_rw    = rw;
        req_wdata = wd;
        req_be    = be;
        req_lock  = lock;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic arbitrate();
        int n = 0;
        while (BR_n !== 1'b0 && n < 20) begin tick(); n++; end
        check("br_asserted", 32'(BR_n), 32'd0);
        BG_n = 1'b0;
        n = 0;
        while (BGACK_n_out !== 1'b0 && n < 20) begin tick(); n++; end
        check("bgack_taken", 32'(BGACK_n_out), 32'd0);
        check("bgack_oe_on", 32'(BGACK_OE), 32'd1);
        check("br_negated_at_grant", 32'(BR_n), 32'd1);
        BG_n = 1'b1;
    endtask

    task automatic wait_as();
        int n = 0;
        while (AS_n_out !== 1'b0 && n < 30) begin tick(); n++; end
        check("as_asserted", 32'(AS_n_out), 32'd0);
    endtask

    task automatic ack(input int dly, input logic berr, input logic [15:0] rd);
        int n = 0;
        tick(dly);
        D_IN    = rd;
        DTACK_n = 1'b0;
        BERR_n  = berr ? 1'b0 : 1'b1;
        while (rsp_valid !== 1'b1 && n < 30) begin tick(); n++; end
        check("rsp_seen", 32'(rsp_valid), 32'd1);
    endtask

    task automatic bus_quiet();
        DTACK_n = 1'b1;
        BERR_n  = 1'b1;
        tick(8);
    endtask

    int r0, b0, g0, a0, l0, u0, n;

    initial begin
        #12;
        check("rst_br", 32'(BR_n), 32'd1);
        check("rst_bgack_oe", 32'(BGACK_OE), 32'd0);
        check("rst_bgack_n", 32'(BGACK_n_out), 32'd1);
        check("rst_bus_oe", 32'(BUS_OE), 32'd0);
        check("rst_d_oe", 32'(D_OE), 32'd0);
        check("rst_strobes", 32'({AS_n_out, UDS_n_out, LDS_n_out, RW_out}), 32'hF);
        check("rst_addr", 32'(ADDR_OUT), 32'd0);
        check("rst_dout", 32'(D_OUT), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        tick(2);
        RESET_n = 1'b1;

        // Plain read, both bytes.
        r0 = n_rsp; b0 = n_br_fall; g0 = n_bgack_rise;
        issue(23'h100000, 1'b1, 16'h0, 2'b11, 1'b0);
        arbitrate();
        wait_as();
        ack(5, 1'b0, 16'hA55A);
        bus_quiet();
        check("rd_as_setup", 32'(t_as_fall - t_busoe_rise), 32'd2);
        check("rd_uds_with_as", 32'(t_uds_fall - t_as_fall), 32'd0);
        check("rd_lds_with_as", 32'(t_lds_fall - t_as_fall), 32'd0);
        check("rd_addr", 32'(addr_at_as), 32'h100000);
        check("rd_rw", 32'(rw_at_as), 32'd1);
        check("rd_rsp_count", 32'(n_rsp - r0), 32'd1);
        check("rd_rdata", 32'(last_rdata), 32'hA55A);
        check("rd_err", 32'(last_err), 32'd0);
        check("rd_br_pulses", 32'(n_br_fall - b0), 32'd1);
        check("rd_bgack_rise", 32'(n_bgack_rise - g0), 32'd1);
        check("rd_released", 32'({BGACK_OE, BUS_OE, BGACK_n_out}), 32'b001);

        // Upper-byte write.
        r0 = n_rsp; l0 = n_lds_fall;
        issue(23'h0ABCDE, 1'b0, 16'h1234, 2'b10, 1'b0);
        arbitrate();
        wait_as();
        ack(4, 1'b0, 16'h0);
        bus_quiet();
        check("wr_ds_delay", 32'(t_uds_fall - t_as_fall), 32'd2);
        check("wr_lds_idle", 32'(n_lds_fall - l0), 32'd0);
        check("wr_rw", 32'(rw_at_as), 32'd0);
        check("wr_dout", 32'(dout_at_as_rise), 32'h1234);
        check("wr_doe_tail", 32'(t_doe_fall - t_as_rise), 32'd1);
        check("wr_err", 32'(last_err), 32'd0);
        check("wr_rdata_kept", 32'(last_rdata), 32'hA55A);
        check("wr_rsp_count", 32'(n_rsp - r0), 32'd1);

        // BERR and DTACK together; ownership held until both negate.
        u0 = n_uds_fall;
        issue(23'h000123, 1'b1, 16'h0, 2'b01, 1'b0);
        arbitrate();
        wait_as();
        ack(3, 1'b1, 16'h5555);
        tick(5);
        check("berr_err", 32'(last_err), 32'd1);
        check("berr_rdata_kept", 32'(last_rdata), 32'hA55A);
        check("berr_hold_bgack", 32'({BGACK_OE, BGACK_n_out, BUS_OE}), 32'b101);
        check("berr_uds_idle", 32'(n_uds_fall - u0), 32'd0);
        bus_quiet();
        check("berr_released", 32'(BGACK_OE), 32'd0);

        // Illegal byte enables: no bus cycle.
        r0 = n_rsp; a0 = n_as_fall; b0 = n_br_fall;
        issue(23'h000040, 1'b1, 16'h0, 2'b00, 1'b0);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 5) begin tick(); n++; end
        check("be0_rsp", 32'(rsp_valid), 32'd1);
        tick(5);
        check("be0_err", 32'(last_err), 32'd1);
        check("be0_rsp_count", 32'(n_rsp - r0), 32'd1);
        check("be0_no_as", 32'(n_as_fall - a0), 32'd0);
        check("be0_no_br", 32'(n_br_fall - b0), 32'd0);

        // Locked pair: one arbitration, bus kept between transfers.
        r0 = n_rsp; b0 = n_br_fall; g0 = n_bgack_rise;
        issue(23'h200000, 1'b1, 16'h0, 2'b11, 1'b1);
        arbitrate();
        wait_as();
        ack(2, 1'b0, 16'h1111);
        bus_quiet();
        check("lock_rdata", 32'(last_rdata), 32'h1111);
        check("lock_held", 32'({BGACK_OE, BGACK_n_out, BUS_OE}), 32'b101);
        check("lock_no_release", 32'(n_bgack_rise - g0), 32'd0);
        issue(23'h200001, 1'b0, 16'hBEEF, 2'b11, 1'b0);
        wait_as();
        ack(2, 1'b0, 16'h0);
        bus_quiet();
        check("lock_single_br", 32'(n_br_fall - b0), 32'd1);
        check("lock_release", 32'(n_bgack_rise - g0), 32'd1);
        check("lock_bgack_oe", 32'(BGACK_OE), 32'd0);
        check("lock_rsp_count", 32'(n_rsp - r0), 32'd2);
        check("lock_dout", 32'(dout_at_as_rise), 32'hBEEF);

        // No DTACK at all.
        r0 = n_rsp;
        issue(23'h300000, 1'b1, 16'h0, 2'b11, 1'b0);
        arbitrate();
        wait_as();
`ifdef Z2M_TIMEOUT_EN
        n = 0;
        while (rsp_valid !== 1'b1 && n < 60) begin tick(); n++; end
        check("tmo_rsp", 32'(rsp_valid), 32'd1);
        tick(2);
        check("tmo_latency", 32'(t_rsp - t_as_fall), 32'd18);
        check("tmo_err", 32'(last_err), 32'd2);
        check("tmo_rdata", 32'(last_rdata), 32'hFFFF);
        bus_quiet();
`else
        tick(1000);
        check("no_tmo_as", 32'(AS_n_out), 32'd0);
        check("no_tmo_rsp", 32'(n_rsp - r0), 32'd0);
        ack(1, 1'b0, 16'h2222);
        bus_quiet();
        check("late_ack_err", 32'(last_err), 32'd0);
        check("late_ack_rdata", 32'(last_rdata), 32'h2222);
`endif

        // Reset during WAIT releases everything without a response.
        issue(23'h400000, 1'b1, 16'h0, 2'b11, 1'b0);
        arbitrate();
        wait_as();
        r0 = n_rsp;
        tick(3);
        #3;
        RESET_n = 1'b0;
        #1;
        check("rst_mid_oe", 32'({BUS_OE, D_OE, BGACK_OE}), 32'd0);
        check("rst_mid_strobes", 32'({AS_n_out, UDS_n_out, LDS_n_out}), 32'b111);
        check("rst_mid_bus_req", 32'({BR_n, BGACK_n_out}), 32'b11);
        tick(3);
        RESET_n = 1'b1;
        tick(5);
        check("rst_mid_no_rsp", 32'(n_rsp - r0), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
